// File: rtl/xa_bf_dly_calc_nl_if.sv
// Bus bundle for the beam-forming delay calculator: run control, position load and per-lane results.
// The master drives the i_* side; the calculator core sits on the slave modport.
interface xa_bf_dly_calc_nl_if #(
    parameter int unsigned P_LANES    = 2,
    parameter int unsigned P_POS_W    = 18,
    parameter int unsigned P_POS_FRAC = 8,
    parameter int unsigned P_DIR_W    = 18,
    parameter int unsigned P_DIR_FRAC = 8,
    parameter int unsigned P_TS_W     = 16
);
    localparam int unsigned PW = P_POS_FRAC + P_DIR_FRAC + 1;

    logic                        i_bm_start;
    logic [9:0]                  i_stave_num;
    logic [P_DIR_W-1:0]          i_dir_x;
    logic [P_DIR_W-1:0]          i_dir_y;
    logic [P_DIR_W-1:0]          i_dir_z;
    logic [P_POS_W-1:0]          i_pos_wr_data;
    logic                        i_pos_wr_en;
    logic [P_LANES*P_TS_W-1:0]   o_tau_sample;
    logic [P_LANES*PW-1:0]       o_tau_precise;
    logic [P_LANES*10-1:0]       o_ch_idx;
    logic [P_LANES-1:0]          o_ch_start;
    logic                        o_busy;
    logic                        o_done;
    logic                        o_sat;
    logic                        o_err;

    modport master (
        output i_bm_start, i_stave_num, i_dir_x, i_dir_y, i_dir_z, i_pos_wr_data, i_pos_wr_en,
        input  o_tau_sample, o_tau_precise, o_ch_idx, o_ch_start, o_busy, o_done, o_sat, o_err
    );

    modport slave (
        input  i_bm_start, i_stave_num, i_dir_x, i_dir_y, i_dir_z, i_pos_wr_data, i_pos_wr_en,
        output o_tau_sample, o_tau_precise, o_ch_idx, o_ch_start, o_busy, o_done, o_sat, o_err
    );
endinterface

// File: rtl/xa_bf_dly_calc_nl.sv
// Per-stave steering delay: dot(position, direction) split into integer sample delay and
// fractional residual, issued over P_LANES staggered lanes with a fixed 8-cycle latency.
module xa_bf_dly_calc_nl #(
    parameter int unsigned P_LANES    = 2,
    parameter int unsigned P_SLOT     = 256,
    parameter int unsigned P_POS_W    = 18,
    parameter int unsigned P_POS_FRAC = 8,
    parameter int unsigned P_DIR_W    = 18,
    parameter int unsigned P_DIR_FRAC = 8,
    parameter int unsigned P_TS_W     = 16
) (
    input  logic               i_clk156m,
    input  logic               i_arst_n,
    xa_bf_dly_calc_nl_if.slave bus
);
    localparam int unsigned F   = P_POS_FRAC + P_DIR_FRAC;
    localparam int unsigned PW  = F + 1;
    localparam int unsigned PRW = P_POS_W + P_DIR_W;
    localparam int unsigned DW  = PRW + 2;
    localparam int unsigned TW  = DW - F;
    localparam int unsigned LSP = P_SLOT / P_LANES;
    localparam int unsigned CW  = (P_SLOT > 1) ? $clog2(P_SLOT) : 1;
    localparam int unsigned LW  = (P_LANES > 1) ? $clog2(P_LANES) : 1;

    localparam logic signed [DW-1:0] D_HALF    = DW'(1) << (F - 1);
    localparam logic        [PW-1:0] PREC_HALF = PW'(1) << (F - 1);
    localparam logic signed [TW-1:0] TS_MAX    = {{(TW-P_TS_W+1){1'b0}}, {(P_TS_W-1){1'b1}}};
    localparam logic signed [TW-1:0] TS_MIN    = ~TS_MAX;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                     state_q, state_d;
    logic [9:0]                 n_q;
    logic signed [P_DIR_W-1:0]  dx_q, dy_q, dz_q;
    logic [9:0]                 slot_q;
    logic [CW-1:0]              cyc_q;
    logic                       done_q, done_d, err_q, issue;
    logic                       legal, start_ok, start_bad;
    logic                       iss_hit;
    logic [LW-1:0]              iss_lane;
    logic [11:0]                iss_idx;

    // Position RAM, registered read, old data on read-during-write
    logic [P_POS_W-1:0]         mem [0:2047];
    logic [10:0]                wr_addr_q, rd_addr;
    logic                       rd_en;
    logic signed [P_POS_W-1:0]  rd_data_q;

    // Job tag pipeline: tv_q[j] marks a live job issued j cycles ago
    logic [7:1]                 tv_q;
    logic [LW-1:0]              tlane_q [1:7];
    logic [9:0]                 tidx_q  [1:7];

    logic signed [P_DIR_W-1:0]  mul_b;
    logic signed [PRW-1:0]      prod_q;
    logic signed [DW-1:0]       acc_q, dr_q;
    logic signed [TW-1:0]       t_val;
    logic [P_TS_W-1:0]          ts7_q;
    logic [PW-1:0]              prec7_q;
    logic                       sat7_q, sat_q;

    logic [P_LANES*P_TS_W-1:0]  ts_o_q;
    logic [P_LANES*PW-1:0]      prec_o_q;
    logic [P_LANES*10-1:0]      idx_o_q;
    logic [P_LANES-1:0]         ch_start_q;

    assign legal     = (bus.i_stave_num != 10'd0) && (bus.i_stave_num <= 10'd682);
    assign start_ok  = bus.i_bm_start && legal;
    assign start_bad = bus.i_bm_start && !legal;

    always_comb begin
        iss_hit  = 1'b0;
        iss_lane = '0;
        iss_idx  = '0;
        for (int unsigned k = 0; k < P_LANES; k++) begin
            if (cyc_q == CW'(k * LSP)) begin
                iss_hit  = 1'b1;
                iss_lane = LW'(k);
                iss_idx  = 12'(slot_q) * 12'(P_LANES) + 12'(k);
            end
        end
    end

    always_ff @(posedge i_clk156m or negedge i_arst_n) begin
        if (!i_arst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Run ends once the last live stave is issued; DRAIN then waits for the tag pipe to empty.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        done_d  = 1'b0;
        if (start_ok) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (iss_hit && (iss_idx < {2'b00, n_q})) begin
                        issue = 1'b1;
                        if (iss_idx == {2'b00, n_q} - 12'd1) state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (tv_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk156m or negedge i_arst_n) begin
        if (!i_arst_n) begin
            n_q    <= '0;
            dx_q   <= '0;
            dy_q   <= '0;
            dz_q   <= '0;
            slot_q <= '0;
            cyc_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            err_q  <= start_bad;
            if (start_ok) begin
                n_q    <= bus.i_stave_num;
                dx_q   <= bus.i_dir_x;
                dy_q   <= bus.i_dir_y;
                dz_q   <= bus.i_dir_z;
                slot_q <= '0;
                cyc_q  <= '0;
            end else if (state_q == RUN) begin
                if (cyc_q == CW'(P_SLOT - 1)) begin
                    cyc_q  <= '0;
                    slot_q <= slot_q + 10'd1;
                end else begin
                    cyc_q <= cyc_q + CW'(1);
                end
            end
        end
    end

    always_comb begin
        rd_en   = issue | tv_q[1] | tv_q[2];
        rd_addr = '0;
        if (issue)        rd_addr = 11'(iss_idx) * 11'd3;
        else if (tv_q[1]) rd_addr = 11'(tidx_q[1]) * 11'd3 + 11'd1;
        else if (tv_q[2]) rd_addr = 11'(tidx_q[2]) * 11'd3 + 11'd2;
    end

    always_ff @(posedge i_clk156m) begin
        if (bus.i_pos_wr_en) mem[wr_addr_q] <= bus.i_pos_wr_data;
        if (rd_en)           rd_data_q      <= mem[rd_addr];
    end

    always_ff @(posedge i_clk156m or negedge i_arst_n) begin
        if (!i_arst_n) wr_addr_q <= '0;
        else           wr_addr_q <= bus.i_pos_wr_en ? wr_addr_q + 11'd1 : '0;
    end

    always_ff @(posedge i_clk156m or negedge i_arst_n) begin
        if (!i_arst_n) begin
            tv_q <= '0;
            for (int unsigned i = 1; i <= 7; i++) begin
                tlane_q[i] <= '0;
                tidx_q[i]  <= '0;
            end
        end else begin
            tv_q       <= start_ok ? '0 : {tv_q[6:1], issue};
            tlane_q[1] <= iss_lane;
            tidx_q[1]  <= iss_idx[9:0];
            for (int unsigned i = 2; i <= 7; i++) begin
                tlane_q[i] <= tlane_q[i-1];
                tidx_q[i]  <= tidx_q[i-1];
            end
        end
    end

    // Serial MAC: x, y, z products arrive on consecutive cycles behind tv_q[2..4].
    always_comb begin
        if (tv_q[1])      mul_b = dx_q;
        else if (tv_q[2]) mul_b = dy_q;
        else              mul_b = dz_q;
    end

    assign t_val = dr_q[DW-1:F];

    always_ff @(posedge i_clk156m or negedge i_arst_n) begin
        if (!i_arst_n) begin
            prod_q  <= '0;
            acc_q   <= '0;
            dr_q    <= '0;
            ts7_q   <= '0;
            prec7_q <= '0;
            sat7_q  <= 1'b0;
        end else begin
            prod_q <= PRW'(rd_data_q) * PRW'(mul_b);
            if (tv_q[2])                acc_q <= DW'(prod_q);
            else if (tv_q[3] | tv_q[4]) acc_q <= acc_q + DW'(prod_q);
            dr_q    <= acc_q + D_HALF;
            prec7_q <= {1'b0, dr_q[F-1:0]} - PREC_HALF;
            sat7_q  <= (t_val > TS_MAX) || (t_val < TS_MIN);
            if (t_val > TS_MAX)      ts7_q <= TS_MAX[P_TS_W-1:0];
            else if (t_val < TS_MIN) ts7_q <= TS_MIN[P_TS_W-1:0];
            else                     ts7_q <= t_val[P_TS_W-1:0];
        end
    end

    always_ff @(posedge i_clk156m or negedge i_arst_n) begin
        if (!i_arst_n) begin
            ts_o_q     <= '0;
            prec_o_q   <= '0;
            idx_o_q    <= '0;
            ch_start_q <= '0;
            sat_q      <= 1'b0;
        end else if (start_ok) begin
            ch_start_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < P_LANES; k++) begin
                ch_start_q[k] <= tv_q[7] && (tlane_q[7] == LW'(k));
                if (tv_q[7] && (tlane_q[7] == LW'(k))) begin
                    ts_o_q[k*P_TS_W +: P_TS_W] <= ts7_q;
                    prec_o_q[k*PW +: PW]       <= prec7_q;
                    idx_o_q[k*10 +: 10]        <= tidx_q[7];
                end
            end
            if (tv_q[7] && sat7_q) sat_q <= 1'b1;
        end
    end

    assign bus.o_tau_sample  = ts_o_q;
    assign bus.o_tau_precise = prec_o_q;
    assign bus.o_ch_idx      = idx_o_q;
    assign bus.o_ch_start    = ch_start_q;
    assign bus.o_busy        = (state_q != IDLE);
    assign bus.o_done        = done_q;
    assign bus.o_sat         = sat_q;
    assign bus.o_err         = err_q;
endmodule

// File: tb/tb_xa_bf_dly_calc_nl.sv
// Self-checking bench: table vectors, random runs against an arithmetic model, restart,
// illegal start and mid-run reset sequences.
module tb_xa_bf_dly_calc_nl;
    localparam int L    = 2;
    localparam int SLOT = 16;
    localparam int TSW  = 16;
    localparam int PWB  = 17;

    logic i_clk156m = 1'b0;
    logic i_arst_n  = 1'b0;
    int   checks = 0;
    int   errors = 0;

    longint mdl_pos [0:2047];
    longint cur_dx, cur_dy, cur_dz;

    typedef struct {
        longint x, y, z, dx, dy, dz;
        longint ts, pr;
        longint sat;
    } vec_t;
    vec_t vecs [6];

    xa_bf_dly_calc_nl_if #(.P_LANES(L), .P_TS_W(TSW)) bus ();

    xa_bf_dly_calc_nl #(.P_LANES(L), .P_SLOT(SLOT), .P_TS_W(TSW)) dut (
        .i_clk156m (i_clk156m),
        .i_arst_n  (i_arst_n),
        .bus       (bus)
    );

    always #5 i_clk156m = ~i_clk156m;

    initial begin
        #600000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: exact dot product, round half up, then clamp the integer part.
    task automatic ref_calc(input int c, output longint ts, output longint pr, output longint sat);
        longint d, t;
        d   = mdl_pos[3*c]*cur_dx + mdl_pos[3*c+1]*cur_dy + mdl_pos[3*c+2]*cur_dz;
        t   = floor_div(d + 32768, 65536);
        pr  = d - t*65536;
        sat = (t > 32767 || t < -32768) ? 1 : 0;
        ts  = (t > 32767) ? 32767 : (t < -32768) ? -32768 : t;
    endtask

    function automatic int strobe_j(input int c);
        return 8 + (c / L) * SLOT + (c % L) * (SLOT / L);
    endfunction

    function automatic longint rnd18();
        return longint'(int'($urandom_range(0, 262143)) - 131072);
    endfunction

    task automatic write_pos(input int nwords);
        for (int i = 0; i < nwords; i++) begin
            @(negedge i_clk156m);
            bus.i_pos_wr_en   = 1'b1;
            bus.i_pos_wr_data = 18'(mdl_pos[i]);
        end
        @(negedge i_clk156m);
        bus.i_pos_wr_en = 1'b0;
    endtask

    task automatic start_run(input int n, input longint dx, input longint dy, input longint dz);
        bus.i_stave_num = 10'(n);
        bus.i_dir_x = 18'(dx);
        bus.i_dir_y = 18'(dy);
        bus.i_dir_z = 18'(dz);
        cur_dx = dx;
        cur_dy = dy;
        cur_dz = dz;
        bus.i_bm_start = 1'b1;
        @(posedge i_clk156m);
        #1;
        bus.i_bm_start = 1'b0;
    endtask

    // Cycle j = 0 is the first cycle after the start edge (slot 0, cycle 0).
    task automatic monitor(input int n, input int stop_j, input int bad_j);
        int done_j;
        logic [L-1:0] exp_st;
        int exp_c [L];
        longint ts, pr, sat, exp_sat;
        done_j  = strobe_j(n - 1) + 1;
        exp_sat = 0;
        for (int j = 0; j <= done_j; j++) begin
            exp_st = '0;
            for (int c = 0; c < n; c++) begin
                if (strobe_j(c) == j) begin
                    exp_st[c % L] = 1'b1;
                    exp_c[c % L]  = c;
                end
            end
            chk("ch_start", longint'(bus.o_ch_start), longint'(exp_st));
            for (int k = 0; k < L; k++) begin
                if (exp_st[k]) begin
                    ref_calc(exp_c[k], ts, pr, sat);
                    if (sat != 0) exp_sat = 1;
                    chk("tau_sample", longint'($signed(bus.o_tau_sample[k*TSW +: TSW])), ts);
                    chk("tau_precise", longint'($signed(bus.o_tau_precise[k*PWB +: PWB])), pr);
                    chk("ch_idx", longint'(bus.o_ch_idx[k*10 +: 10]), longint'(exp_c[k]));
                end
            end
            chk("done", longint'(bus.o_done), longint'(j == done_j));
            chk("busy", longint'(bus.o_busy), longint'(j != done_j));
            if (j == 0) chk("sat_clear", longint'(bus.o_sat), 0);
            if (j == done_j) chk("sat_sticky", longint'(bus.o_sat), exp_sat);
            if (bad_j >= 0 && j == bad_j + 1) begin
                bus.i_bm_start = 1'b0;
                chk("err_in_run", longint'(bus.o_err), 1);
            end
            if (j == stop_j) return;
            if (bad_j >= 0 && j == bad_j) begin
                bus.i_stave_num = 10'd0;
                bus.i_bm_start  = 1'b1;
            end
            if (j != done_j) begin
                @(posedge i_clk156m);
                #1;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ts"}, longint'(bus.o_tau_sample), 0);
        chk({tag, "_prec"}, longint'(bus.o_tau_precise), 0);
        chk({tag, "_idx"}, longint'(bus.o_ch_idx), 0);
        chk({tag, "_strobe"}, longint'(bus.o_ch_start), 0);
        chk({tag, "_busy"}, longint'(bus.o_busy), 0);
        chk({tag, "_done"}, longint'(bus.o_done), 0);
        chk({tag, "_sat"}, longint'(bus.o_sat), 0);
        chk({tag, "_err"}, longint'(bus.o_err), 0);
    endtask

    task automatic illegal_start(input int n);
        bus.i_stave_num = 10'(n);
        bus.i_bm_start  = 1'b1;
        @(posedge i_clk156m);
        #1;
        bus.i_bm_start = 1'b0;
        chk("err_pulse", longint'(bus.o_err), 1);
        chk("err_busy", longint'(bus.o_busy), 0);
        @(posedge i_clk156m);
        #1;
        chk("err_clear", longint'(bus.o_err), 0);
        chk("err_busy2", longint'(bus.o_busy), 0);
    endtask

    initial begin
        vecs[0] = '{x: 256,     y: 0,    z: 0,   dx: 704,    dy: 0,  dz: 0,   ts: 3,      pr: -16384, sat: 0};
        vecs[1] = '{x: 131071,  y: 0,    z: 0,   dx: 131071, dy: 0,  dz: 0,   ts: 32767,  pr: 1,      sat: 1};
        vecs[2] = '{x: -256,    y: 0,    z: 0,   dx: 704,    dy: 0,  dz: 0,   ts: -3,     pr: 16384,  sat: 0};
        vecs[3] = '{x: 256,     y: 0,    z: 0,   dx: 640,    dy: 0,  dz: 0,   ts: 3,      pr: -32768, sat: 0};
        vecs[4] = '{x: -131072, y: 0,    z: 0,   dx: 131071, dy: 0,  dz: 0,   ts: -32768, pr: 0,      sat: 1};
        vecs[5] = '{x: 100,     y: -200, z: 300, dx: 50,     dy: 60, dz: -70, ts: 0,      pr: -28000, sat: 0};

        bus.i_bm_start    = 1'b0;
        bus.i_stave_num   = '0;
        bus.i_dir_x       = '0;
        bus.i_dir_y       = '0;
        bus.i_dir_z       = '0;
        bus.i_pos_wr_data = '0;
        bus.i_pos_wr_en   = 1'b0;
        for (int i = 0; i < 2048; i++) mdl_pos[i] = 0;

        repeat (3) @(posedge i_clk156m);
        #1;
        chk_all_zero("reset");
        @(negedge i_clk156m);
        i_arst_n = 1'b1;
        @(posedge i_clk156m);
        #1;
        chk_all_zero("post_reset");

        foreach (vecs[v]) begin
            mdl_pos[0] = vecs[v].x;
            mdl_pos[1] = vecs[v].y;
            mdl_pos[2] = vecs[v].z;
            write_pos(3);
            start_run(1, vecs[v].dx, vecs[v].dy, vecs[v].dz);
            monitor(1, -1, -1);
            chk("tbl_ts", longint'($signed(bus.o_tau_sample[TSW-1:0])), vecs[v].ts);
            chk("tbl_prec", longint'($signed(bus.o_tau_precise[PWB-1:0])), vecs[v].pr);
            chk("tbl_sat", longint'(bus.o_sat), vecs[v].sat);
        end

        illegal_start(0);
        illegal_start(683);

        mdl_pos[0] = 256;
        mdl_pos[1] = 0;
        mdl_pos[2] = 0;
        for (int i = 3; i < 15; i++) mdl_pos[i] = rnd18();
        write_pos(15);
        start_run(5, 704, 0, 0);
        monitor(5, -1, 10);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 12));
            for (int i = 0; i < 3*n; i++) mdl_pos[i] = rnd18();
            write_pos(3*n);
            if (r % 2 == 0) start_run(n, rnd18(), rnd18(), rnd18());
            else start_run(n, longint'(int'($urandom_range(0, 4095)) - 2048),
                           longint'(int'($urandom_range(0, 4095)) - 2048),
                           longint'(int'($urandom_range(0, 4095)) - 2048));
            monitor(n, -1, -1);
        end

        for (int i = 0; i < 2046; i++) mdl_pos[i] = longint'(int'($urandom_range(0, 8191)) - 4096);
        write_pos(2046);
        start_run(682, 300, -500, 700);
        monitor(682, -1, -1);

        start_run(4, 1000, 2000, -3000);
        monitor(4, SLOT + 3, -1);
        start_run(2, -700, 400, 900);
        monitor(2, -1, -1);
        repeat (12) begin
            @(posedge i_clk156m);
            #1;
            chk("restart_quiet_strobe", longint'(bus.o_ch_start), 0);
            chk("restart_quiet_done", longint'(bus.o_done), 0);
        end

        start_run(3, 1234, -4321, 555);
        monitor(3, 20, -1);
        i_arst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        @(posedge i_clk156m);
        #1;
        chk_all_zero("rst_edge");
        @(negedge i_clk156m);
        i_arst_n = 1'b1;
        repeat (30) begin
            @(posedge i_clk156m);
            #1;
            chk("rst_no_strobe", longint'(bus.o_ch_start), 0);
            chk("rst_no_done", longint'(bus.o_done), 0);
            chk("rst_no_busy", longint'(bus.o_busy), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xa_bf_dly_calc_nl.md
# xa_bf_dly_calc_nl

Parametrised, fixed-point successor to the beam-forming delay calculator in the FA_xa_bf chain. For each beam it computes the steering delay of every stave as the dot product of a stored 3-D stave position with a per-beam direction vector, pre-scaled by fs/c, and splits it into an integer sample delay and a fractional residual. Stave count is set at run time. Results are distributed over P_LANES output lanes with staggered issue slots. Outputs feed the per-lane delay/interpolation stages.

## Interface
- P_LANES, 2 — output lanes, 1..4.
- P_SLOT, 256 — cycles per issue slot; must be divisible by P_LANES, with P_SLOT/P_LANES ≥ 4.
- P_POS_W, 18 — signed position word width; P_POS_FRAC = 8 fractional bits.
- P_DIR_W, 18 — signed direction word width; P_DIR_FRAC = 8 fractional bits.
- P_TS_W, 16 — signed integer-delay output width.
- Derived: F = P_POS_FRAC + P_DIR_FRAC; precise width PW = F+1.
- i_clk156m  in  1  — the block's single clock.
- i_arst_n  in  1  — asynchronous, active-low reset.
- i_bm_start  in  1  — beam start pulse.
- i_stave_num  in  10  — stave count N, valid 1..682; sampled at start.
- i_dir_x / i_dir_y / i_dir_z  in  P_DIR_W each  — direction vector; sampled at start.
- i_pos_wr_data  in  P_POS_W  — position write data.
- i_pos_wr_en  in  1  — position write enable; consecutive words go to consecutive addresses.
- o_tau_sample  out  P_LANES*P_TS_W  — integer delay per lane, packed with lane 0 in the LSBs.
- o_tau_precise  out  P_LANES*PW  — fractional residual per lane.
- o_ch_idx  out  P_LANES*10  — stave index per lane.
- o_ch_start  out  P_LANES  — per-lane result strobe.
- o_busy  out  1  — run in progress.
- o_done  out  1  — run-complete pulse.
- o_sat  out  1  — sticky saturation flag; cleared at start.
- o_err  out  1  — illegal-start pulse.

## Operation
- **Position RAM**
  - 2048 × P_POS_W, inferred, 1-cycle registered read.
  - Write address resets to 0 whenever i_pos_wr_en is low and increments per written word. Layout is x,y,z at 3·idx, 3·idx+1, 3·idx+2.
  - Writes during a run are allowed. Read-during-write to the same address returns old data.
- **Start**
  - i_bm_start with i_stave_num in 1..682 latches N and the direction vector, clears o_sat, sets busy and enters RUN.
  - If i_stave_num is 0 or >682: pulse o_err and leave state unchanged.
- **Sequencing**
  - FSM states: IDLE → RUN → DRAIN → IDLE.
  - RUN walks slots s = 0..ceil(N/P_LANES)−1.
  - Lane k issues its job at slot cycle k·P_SLOT/P_LANES with ch_idx = s·P_LANES + k.
  - A job with ch_idx ≥ N is skipped: no RAM read and no strobe.
  - After the last slot ends, DRAIN waits until the pipeline is empty. o_done then pulses for 1 cycle and busy clears.
- **Restart**
  - i_bm_start during RUN or DRAIN aborts the current run and restarts from slot 0.
  - Every in-flight job of the aborted run is invalidated: no strobe is produced for it.
- **Arithmetic**
  - D = x·dx + y·dy + z·dz, signed, full precision (P_POS_W+P_DIR_W+2 bits), F fractional bits.
  - T = (D + 2^(F−1)) >>> F, i.e. round half toward +∞.
  - precise = D − (T << F), range [−2^(F−1), 2^(F−1)−1].
  - tau_sample = T saturated to P_TS_W signed. On saturation, set o_sat; precise still uses the unsaturated T.
- **Outputs**
  - Each lane's registers update only on that lane's strobe and hold their value otherwise.

## Timing
- Job issued at cycle t0: read addresses at t0, t0+1, t0+2.
- Lane outputs register at t0+8, and o_ch_start[k] is high during that same cycle. Fixed latency: 8.
- o_done pulses 1 cycle after the last strobe of the run. If the final slot contains only skipped jobs, o_done pulses at slot end + 8.
- o_busy rises the cycle after i_bm_start and falls together with o_done.
- Slot s+1 begins exactly P_SLOT cycles after slot s.
- Reset values: all data and index outputs 0; o_ch_start, o_busy, o_done, o_sat, o_err all 0; FSM in IDLE; write address 0.
- Reset asserted mid-run: all state clears immediately, and no strobe or o_done is produced afterwards.

## Test plan
- **Positive rounding.** P_LANES=2, N=5. Stave 0 = (256,0,0), direction = (704,0,0). Expected: lane 0 strobes 8 cycles after its issue with ch_idx 0, tau_sample 3, precise −16384. Strobes run 0,1,2,3,4 alternating lanes. The lane-1 job of slot 2 (ch_idx 5) is skipped. o_done follows the ch 4 strobe by 1 cycle.
- **Negative value and exact half.** x = −256, dx = 704 → tau_sample −3, precise +16384. x = 256, dx = 640 (D = 2.5) → tau_sample 3, precise −32768.
- **Saturation.** x = 131071, dx = 131071 → tau_sample 32767, o_sat = 1. o_sat clears on the next start.
- **Illegal starts.** i_stave_num = 0 → o_err 1 cycle, o_busy stays 0. i_stave_num = 683 → same response.
- **Restart.** Second i_bm_start at slot 1 cycle 3 with N=2. Expected: no strobe for any old job; new ch 0 and ch 1 results only; exactly one o_done.
- **Reset mid-run.** Drop i_arst_n during DRAIN → all outputs 0 next edge; no o_done.
